// File: rtl/pio_debounce_pwm.sv
// pio_debounce_pwm
//   Avalon-MM parallel I/O slave: debounced switch inputs with edge capture
//   and a level interrupt, plus register-driven LED outputs with one global
//   PWM brightness (DUTY) setting.
//
// Ports
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   avs_address    word address (0 DATA, 1 LED, 2 IRQ_MASK, 3 EDGE, 4 DUTY, 5 RAW)
//   avs_read       read strobe; avs_readdata is valid the following cycle
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_readdata   registered read data, held until the next read
//   sw_in          raw asynchronous switch pins
//   led_out        registered, PWM-gated LED drive
//   irq            registered level interrupt, |(EDGE & IRQ_MASK)
module pio_debounce_pwm #(
  parameter int IN_WIDTH        = 4,
  parameter int OUT_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0,
  parameter int PWM_BITS        = 8
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  input  logic [IN_WIDTH-1:0]  sw_in,
  output logic [OUT_WIDTH-1:0] led_out,
  output logic                 irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWM_BITS:0] DUTY_RST = {1'b1, {PWM_BITS{1'b0}}};

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_LED  = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_EDGE = 3'd3;
  localparam logic [2:0] A_DUTY = 3'd4;
  localparam logic [2:0] A_RAW  = 3'd5;

  logic [IN_WIDTH-1:0]  sync1_q, sync1_d;
  logic [IN_WIDTH-1:0]  sync_q, sync_d;
  logic [IN_WIDTH-1:0]  stable_q, stable_d;
  logic [IN_WIDTH-1:0]  stable_prev_q, stable_prev_d;
  logic [CNT_W-1:0]     cnt_q [IN_WIDTH];
  logic [CNT_W-1:0]     cnt_d [IN_WIDTH];
  logic [IN_WIDTH-1:0]  edge_q, edge_d;
  logic [IN_WIDTH-1:0]  mask_q, mask_d;
  logic [OUT_WIDTH-1:0] led_q, led_d;
  logic [PWM_BITS:0]    duty_q, duty_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [OUT_WIDTH-1:0] led_out_q, led_out_d;
  logic                 irq_q, irq_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [IN_WIDTH-1:0]  rise, fall, edge_evt;
  logic                 pwm_on;
  logic [31:0]          rd_mux;
  logic                 wr_led, wr_mask, wr_edge, wr_duty;
  logic                 unused_wdata;

  // Upper write-data bits are don't-care for narrow configurations.
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    // Two-flop synchroniser for the asynchronous pins.
    sync1_d = sw_in;
    sync_d  = sync1_q;

    // Debounce: a bit is accepted once sync_q has disagreed with stable for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]    = '0;
        stable_d[i] = sync_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    stable_prev_d = stable_q;

    rise = stable_q & ~stable_prev_q;
    fall = ~stable_q & stable_prev_q;
    if (EDGE_MODE == 0)      edge_evt = rise;
    else if (EDGE_MODE == 1) edge_evt = fall;
    else                     edge_evt = rise | fall;

    wr_led  = avs_write && (avs_address == A_LED);
    wr_mask = avs_write && (avs_address == A_MASK);
    wr_edge = avs_write && (avs_address == A_EDGE);
    wr_duty = avs_write && (avs_address == A_DUTY);

    led_d  = wr_led  ? avs_writedata[OUT_WIDTH-1:0] : led_q;
    mask_d = wr_mask ? avs_writedata[IN_WIDTH-1:0]  : mask_q;
    duty_d = wr_duty ? avs_writedata[PWM_BITS:0]    : duty_q;

    // W1C is applied first so that a new edge in the same cycle survives.
    edge_d = edge_q;
    if (wr_edge) edge_d = edge_q & ~avs_writedata[IN_WIDTH-1:0];
    edge_d = edge_d | edge_evt;

    irq_d = |(edge_q & mask_q);

    // DUTY is one bit wider than the counter so 2^PWM_BITS means always on.
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    pwm_on    = ({1'b0, pwm_cnt_q} < duty_q);
    led_out_d = led_q & {OUT_WIDTH{pwm_on}};

    // Read mux sees register values before any same-cycle write.
    rd_mux = '0;
    case (avs_address)
      A_DATA:  rd_mux[IN_WIDTH-1:0]  = stable_q;
      A_LED:   rd_mux[OUT_WIDTH-1:0] = led_q;
      A_MASK:  rd_mux[IN_WIDTH-1:0]  = mask_q;
      A_EDGE:  rd_mux[IN_WIDTH-1:0]  = edge_q;
      A_DUTY:  rd_mux[PWM_BITS:0]    = duty_q;
      A_RAW:   rd_mux[IN_WIDTH-1:0]  = sync_q;
      default: rd_mux = '0;
    endcase
    rdata_d = avs_read ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q       <= '0;
      sync_q        <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= '0;
      edge_q        <= '0;
      mask_q        <= '0;
      led_q         <= '0;
      duty_q        <= DUTY_RST;
      pwm_cnt_q     <= '0;
      led_out_q     <= '0;
      irq_q         <= 1'b0;
      rdata_q       <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync_q        <= sync_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= cnt_d[i];
      edge_q        <= edge_d;
      mask_q        <= mask_d;
      led_q         <= led_d;
      duty_q        <= duty_d;
      pwm_cnt_q     <= pwm_cnt_d;
      led_out_q     <= led_out_d;
      irq_q         <= irq_d;
      rdata_q       <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign led_out      = led_out_q;
  assign irq          = irq_q;

endmodule
